booth_mult_arbiter: RTL and testbench
=====================================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one sequential radix-4 Booth multiplier core among NREQ requesters.
//  Round-robin arbitration with valid/ready handshake; operands latched at grant.
//  Sequences the core: load, then WIDTH/2 step cycles; captures the product and returns it with the requester ID.
//  One operation outstanding at a time.
// PARAMETERS
//  WIDTH  32  signed operand width, must be even; product is 2*WIDTH
//  NREQ   4   number of requesters
//  ID_W   2   requester ID width, equal to clog2(NREQ)
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            synchronous, active-low
//  en           in   1            global enable; low freezes the whole block
//  req_valid    in   NREQ         per-requester request
//  req_ready    out  NREQ         one-hot grant; handshake when valid&ready
//  req_a        in   NREQ*WIDTH   packed multiplicands; slice i belongs to requester i
//  req_b        in   NREQ*WIDTH   packed multipliers
//  rsp_valid    out  1            result available
//  rsp_ready    in   1            consumer accepts the result
//  rsp_id       out  ID_W         requester that owns the result
//  rsp_product  out  2*WIDTH      signed product
//  core_load    out  1            core samples core_a/core_b and clears its accumulator
//  core_en      out  1            core advances one radix-4 step
//  core_a       out  WIDTH        latched multiplicand to the core
//  core_b       out  WIDTH        latched multiplier to the core
//  core_product in   2*WIDTH      core result; valid the cycle after the last core_en
//  busy         out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at a clk edge)
//   - Applies to all outputs and state. Takes priority over en.
//   - state=IDLE. All outputs 0. Operand and product registers 0.
//   - RR pointer = NREQ-1, so requester 0 has highest priority.
//   - Mid-operation: the operation is aborted and no response is produced.
//   - req_ready is held 0 while reset==0.
//  en==0: state, counter and registers hold; core_en=0, core_load=0, req_ready=0.
//   - rsp_valid/rsp_id/rsp_product keep their values.
//   - A rsp handshake still completes if rsp_valid&rsp_ready.
//  FSM
//   - IDLE: req_ready = grant from rr_arbiter (combinational from req_valid and pointer).
//     On handshake: latch req_a/req_b slice and the ID, pointer := granted index, -> LOAD.
//   - LOAD (1 cycle): core_load=1 -> RUN, counter := 0.
//   - RUN (ITERS=WIDTH/2 cycles): core_en=1, counter++. After the ITERS-th step -> CAPT.
//   - CAPT (1 cycle): rsp_product := core_product; rsp_id := latched ID -> RESP.
//   - RESP: rsp_valid=1. On rsp_ready -> IDLE, clearing rsp_valid at that edge.
//  Latency: accept at edge 0 -> rsp_valid first high in cycle ITERS+3 (19 for WIDTH=32).
//   - A new grant is possible no earlier than the cycle after the rsp handshake.
//  Arbitration
//   - Search starts at pointer+1 mod NREQ; the first valid requester wins.
//   - The pointer updates only on handshake.
//   - No requests valid: req_ready=0, stay IDLE.
//  Requester rules
//   - Must hold valid and operands until ready.
//   - Dropping valid before ready means nothing is accepted.
//   - Operands may change freely after the handshake.
//  RESP stall: rsp_id and rsp_product stay stable; no req_ready to any requester.
//  Arithmetic
//   - Two's-complement signed; full 2*WIDTH product, never truncated.
//   - Product correctness is the core's job; this block adds no arithmetic.
// STRUCTURE
//  Package booth_mult_pkg:
//   - state encoding IDLE/LOAD/RUN/CAPT/RESP;
//   - ITERS = WIDTH/2; counter width clog2(ITERS+1).
//  Sub-module rr_arbiter: NREQ-wide round-robin picker with inputs req and pointer, output one-hot grant and index.
//  The multiplier core is instantiated by the parent, not here.
//  Benches pair this block with the existing sequential core.
// TESTING
//  1. Req0 only: a=553524, b=840.
//     -> req_ready[0] pulses 1 cycle; rsp_valid in cycle 19; product 464960160; id 0.
//  2. After reset, all 4 valid and held, rsp_ready=1.
//     -> grants in order 0,1,2,3.
//     -> req3 a=-259, b=-259 returns 67081 with id 3.
//  3. rsp_ready low 5 cycles in RESP.
//     -> rsp_valid/id/product stable; req_ready stays 0.
//     -> after the handshake, the next grant follows in the cycle after.
//  4. en low 3 cycles during RUN, a=553524, b=-259.
//     -> rsp_valid in cycle 22; product -143362716.
//  5. reset low mid-RUN.
//     -> the next cycle has all outputs 0 and busy 0; no response ever appears.
//     -> with req1 and req0 valid afterwards, req0 is granted first.
//  6. Back-to-back, rsp_ready=1.
//     -> (-1199060305, 0) gives 0.
//     -> (1, 1348760118) gives 1348760118.
//     -> spacing between the two grants is 20 cycles.

Source files
------------

// File: rtl/booth_mult_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the Booth multiplier arbiter.
package booth_mult_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_e;

    function automatic int iters_of(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Request, response and core-control bundle between the requesters, the arbiter and the core.
interface booth_mult_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  core_load;
    logic                  core_en;
    logic [WIDTH-1:0]      core_a;
    logic [WIDTH-1:0]      core_b;
    logic [2*WIDTH-1:0]    core_product;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, core_product,
        output req_ready, rsp_valid, rsp_id, rsp_product, core_load, core_en, core_a, core_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, core_product,
        input  req_ready, rsp_valid, rsp_id, rsp_product, core_load, core_en, core_a, core_b
    );
endinterface

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Round-robin picker: the search starts one past the pointer and the first valid request wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] idx_o
);
    int              pos_s;
    logic [ID_W-1:0] cand_s;
    logic            found_s;

    // Scan all NREQ positions in rotated order, keeping the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = ptr_i;
        found_s = 1'b0;
        pos_s   = 0;
        cand_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos_s  = (int'(ptr_i) + k) % NREQ;
            cand_s = ID_W'(pos_s);
            if (!found_s && req_i[cand_s]) begin
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential radix-4 Booth core among NREQ requesters: grant, load, WIDTH/2 steps,
// capture, then hold the tagged product until the consumer takes it.
module booth_mult_arbiter
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        busy,
    booth_mult_if.slave bus
);
    localparam int ITERS = iters_of(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]    grant_s;
    logic [NREQ-1:0]    ready_s;
    logic [ID_W-1:0]    gidx_s;
    logic               active_s;
    logic               accept_s;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_arbiter (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (gidx_s)
    );

    // Reset is synchronous, so grants and core strobes are also masked while it is asserted.
    assign active_s = reset && en;
    assign ready_s  = (active_s && (state_q == IDLE)) ? grant_s : '0;
    assign accept_s = |(ready_s & bus.req_valid);

    assign bus.req_ready   = ready_s;
    assign bus.core_load   = active_s && (state_q == LOAD);
    assign bus.core_en     = active_s && (state_q == RUN);
    assign bus.core_a      = a_q;
    assign bus.core_b      = b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = prod_q;
    assign busy            = (state_q != IDLE);

    // Next-state logic; the response handshake completes even while en is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = bus.req_a[int'(gidx_s) * WIDTH +: WIDTH];
                    b_d     = bus.req_b[int'(gidx_s) * WIDTH +: WIDTH];
                    id_d    = gidx_s;
                    ptr_d   = gidx_s;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (active_s) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (active_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = CAPT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            CAPT: begin
                if (active_s) begin
                    prod_d      = bus.core_product;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = CAPT;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; the pointer resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            ptr_q       <= ID_W'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter with a behavioural sequential core attached; a transaction-level
// model predicts every output each cycle, plus table vectors and directed corner sequences.
module tb_booth_mult_arbiter;
    localparam int W     = 32;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int ITERS = W / 2;
    localparam int LAT   = ITERS + 3;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic busy;

    booth_mult_if #(.WIDTH(W), .NREQ(NREQ), .ID_W(ID_W)) bif ();

    booth_mult_arbiter #(.WIDTH(W), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .busy  (busy),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // Core model: the product is only right after exactly ITERS steps since the last load.
    logic [W-1:0] core_a_m = '0;
    logic [W-1:0] core_b_m = '0;
    int           core_steps = 0;
    always @(posedge clk) begin
        if (bif.core_load) begin
            core_a_m   <= bif.core_a;
            core_b_m   <= bif.core_b;
            core_steps <= 0;
        end else if (bif.core_en) begin
            core_steps <= core_steps + 1;
        end
    end
    assign bif.core_product = (core_steps == ITERS) ? smul(core_a_m, core_b_m)
                                                    : ~smul(core_a_m, core_b_m);

    // Transaction-level reference state.
    bit              m_idle;
    bit              m_resp;
    int              m_left;
    logic [ID_W-1:0] m_ptr, m_id, m_pid;
    logic [2*W-1:0]  m_prod, m_pprod;
    logic [W-1:0]    m_ca, m_cb;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [NREQ-1:0] obs_ready;
    logic            obs_rsp_valid;
    logic [ID_W-1:0] obs_rsp_id;
    logic [2*W-1:0]  obs_rsp_prod;

    typedef struct {
        int unsigned    rid;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d): timed out waiting for the DUT", name, cyc);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input logic [ID_W-1:0] p);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(p) + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_resp  = 1'b0;
        m_left  = 0;
        m_ptr   = ID_W'(NREQ - 1);
        m_id    = '0;
        m_pid   = '0;
        m_prod  = '0;
        m_pprod = '0;
        m_ca    = '0;
        m_cb    = '0;
    endtask

    // One clock: compare all outputs with the model, advance the model across the edge.
    task automatic step();
        int              win;
        logic [NREQ-1:0] e_ready;
        #1;
        obs_ready     = bif.req_ready;
        obs_rsp_valid = bif.rsp_valid;
        obs_rsp_id    = bif.rsp_id;
        obs_rsp_prod  = bif.rsp_product;
        win = (reset && en && m_idle) ? rr_pick(bif.req_valid, m_ptr) : -1;
        e_ready = '0;
        if (win >= 0) e_ready[win] = 1'b1;
        chk("req_ready", bif.req_ready, e_ready);
        chk("busy", busy, !m_idle);
        chk("rsp_valid", bif.rsp_valid, m_resp);
        chk("rsp_id", bif.rsp_id, m_id);
        chk("rsp_product", bif.rsp_product, m_prod);
        chk("core_load", bif.core_load, reset && en && !m_idle && !m_resp && (m_left == ITERS + 2));
        chk("core_en", bif.core_en,
            reset && en && !m_idle && !m_resp && (m_left >= 2) && (m_left <= ITERS + 1));
        chk("core_a", bif.core_a, m_ca);
        chk("core_b", bif.core_b, m_cb);
        if (!reset) begin
            model_reset();
        end else if (m_resp) begin
            if (bif.rsp_ready) begin
                m_resp = 1'b0;
                m_idle = 1'b1;
            end
        end else if (m_idle) begin
            if (win >= 0) begin
                m_ca    = bif.req_a[win * W +: W];
                m_cb    = bif.req_b[win * W +: W];
                m_pprod = smul(m_ca, m_cb);
                m_pid   = win[ID_W-1:0];
                m_ptr   = win[ID_W-1:0];
                m_idle  = 1'b0;
                m_left  = ITERS + 2;
            end
        end else if (en) begin
            m_left--;
            if (m_left == 0) begin
                m_resp = 1'b1;
                m_id   = m_pid;
                m_prod = m_pprod;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_ready(input string name, output int gcyc);
        gcyc = -1;
        for (int t = 0; t < 64 && gcyc < 0; t++) begin
            step();
            if (obs_ready != '0) gcyc = cyc - 1;
        end
        if (gcyc < 0) timeout(name);
    endtask

    task automatic wait_rsp(input string name, output int rcyc);
        rcyc = -1;
        for (int t = 0; t < 100 && rcyc < 0; t++) begin
            step();
            if (obs_rsp_valid) rcyc = cyc - 1;
        end
        if (rcyc < 0) timeout(name);
    endtask

    task automatic set_op(input int unsigned r, input logic [W-1:0] a, input logic [W-1:0] b);
        bif.req_a[r * W +: W] = a;
        bif.req_b[r * W +: W] = b;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int g, g2, r, nresp;
        vecs[0] = '{32'd0, 32'd553524, 32'd840, 64'd464960160};
        vecs[1] = '{32'd3, -32'sd259, -32'sd259, 64'd67081};
        vecs[2] = '{32'd1, 32'd553524, -32'sd259, -64'sd143362716};
        vecs[3] = '{32'd2, -32'sd1199060305, 32'd0, 64'd0};
        vecs[4] = '{32'd0, 32'd1, 32'd1348760118, 64'd1348760118};
        vecs[5] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'd2, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};

        reset         = 1'b0;
        en            = 1'b1;
        bif.rsp_ready = 1'b0;
        bif.req_valid = '0;
        bif.req_a     = '0;
        bif.req_b     = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        step();
        reset = 1'b1;
        step();

        // Table vectors, one requester at a time, consumer always ready.
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.req_valid = '0;
            bif.req_valid[vecs[i].rid] = 1'b1;
            set_op(vecs[i].rid, vecs[i].a, vecs[i].b);
            wait_ready("vec_grant", g);
            chk("vec_grant_onehot", obs_ready, 4'b0001 << vecs[i].rid);
            bif.req_valid = '0;
            bif.req_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
            bif.req_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
            wait_rsp("vec_rsp", r);
            chk("vec_latency", r - g, LAT);
            chk("vec_id", obs_rsp_id, vecs[i].rid);
            chk("vec_product", obs_rsp_prod, vecs[i].prod);
        end

        // All four valid after reset: grants must come out 0,1,2,3.
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int q = 0; q < NREQ; q++) set_op(q, pick_operand(), pick_operand());
        set_op(3, -32'sd259, -32'sd259);
        bif.req_valid = 4'b1111;
        for (int n = 0; n < NREQ; n++) begin
            wait_ready("order_grant", g);
            chk("order_grant", obs_ready, 4'b0001 << n);
            bif.req_valid = bif.req_valid & ~obs_ready;
            wait_rsp("order_rsp", r);
            chk("order_id", obs_rsp_id, n);
        end
        chk("order_req3_product", obs_rsp_prod, 64'd67081);

        // Response stall for 5 cycles with another requester waiting.
        bif.rsp_ready = 1'b0;
        set_op(2, 32'd553524, 32'd840);
        bif.req_valid = 4'b0100;
        wait_ready("stall_grant", g);
        bif.req_valid = 4'b0010;
        set_op(1, pick_operand(), pick_operand());
        wait_rsp("stall_rsp", r);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_rsp_valid", obs_rsp_valid, 1'b1);
            chk("stall_rsp_id", obs_rsp_id, 2'd2);
            chk("stall_rsp_product", obs_rsp_prod, 64'd464960160);
            chk("stall_no_ready", obs_ready, 4'b0000);
        end
        bif.rsp_ready = 1'b1;
        step();
        chk("stall_release_valid", obs_rsp_valid, 1'b1);
        step();
        chk("stall_next_grant", obs_ready, 4'b0010);
        bif.req_valid = '0;
        wait_rsp("stall_drain", r);

        // en low for 3 cycles during RUN stretches latency by 3.
        set_op(0, 32'd553524, -32'sd259);
        bif.req_valid = 4'b0001;
        wait_ready("en_grant", g);
        bif.req_valid = '0;
        repeat (5) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_rsp("en_rsp", r);
        chk("en_latency", r - g, LAT + 3);
        chk("en_product", obs_rsp_prod, -64'sd143362716);

        // Reset in the middle of RUN aborts the operation.
        set_op(2, 32'd12345, 32'd678);
        bif.req_valid = 4'b0100;
        wait_ready("abort_grant", g);
        bif.req_valid = '0;
        repeat (6) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp_valid", bif.rsp_valid, 1'b0);
        chk("abort_rsp_id", bif.rsp_id, 2'd0);
        chk("abort_rsp_product", bif.rsp_product, 64'd0);
        chk("abort_core_load", bif.core_load, 1'b0);
        chk("abort_core_en", bif.core_en, 1'b0);
        chk("abort_core_ab", {bif.core_a, bif.core_b}, 64'd0);
        nresp = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (obs_rsp_valid) nresp++;
        end
        chk("abort_no_response", nresp, 0);
        bif.req_valid = 4'b0011;
        step();
        chk("abort_req0_first", obs_ready, 4'b0001);
        bif.req_valid = 4'b0010;
        wait_rsp("abort_drain0", r);
        wait_ready("abort_grant1", g);
        chk("abort_req1_next", obs_ready, 4'b0010);
        bif.req_valid = '0;
        wait_rsp("abort_drain1", r);

        // Back-to-back from one requester holding valid.
        set_op(0, -32'sd1199060305, 32'd0);
        bif.req_valid = 4'b0001;
        wait_ready("b2b_grant1", g);
        set_op(0, 32'd1, 32'd1348760118);
        wait_rsp("b2b_rsp1", r);
        chk("b2b_product1", obs_rsp_prod, 64'd0);
        wait_ready("b2b_grant2", g2);
        bif.req_valid = '0;
        chk("b2b_spacing", g2 - g, 20);
        wait_rsp("b2b_rsp2", r);
        chk("b2b_product2", obs_rsp_prod, 64'd1348760118);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 299) != 0);
            en            = ($urandom_range(0, 9) != 0);
            bif.rsp_ready = ($urandom_range(0, 1) == 1);
            bif.req_valid = NREQ'($urandom_range(0, 15));
            for (int q = 0; q < NREQ; q++) set_op(q, pick_operand(), pick_operand());
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
